// File: rtl/lut_fetch_pkg.sv
// Shared definitions for the activation LUT front end: default widths,
// FSM state encoding, index bias and index saturation limit.
package lut_fetch_pkg;

  localparam int LUT_IDX_W  = 4;
  localparam int LUT_FRAC_W = 4;
  localparam int LUT_DATA_W = 8;

  // XOR with the bias turns the signed top nibble into an unsigned table index
  localparam logic [LUT_IDX_W-1:0] IDX_BIAS = 4'b1000;
  localparam logic [LUT_IDX_W-1:0] IDX_SAT  = 4'b1111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_BASE = 3'd1,
    RD_NEXT = 3'd2,
    RD_LAST = 3'd3,
    OUT     = 3'd4
  } state_t;

endpackage

// File: rtl/lut_index_split.sv
// Combinational split of a signed activation into table index, saturated
// neighbour index and fractional remainder.
module lut_index_split
  import lut_fetch_pkg::*;
#(
  parameter int                   IDX_W  = LUT_IDX_W,
  parameter int                   FRAC_W = LUT_FRAC_W,
  parameter int                   DATA_W = LUT_DATA_W,
  parameter logic [IDX_W-1:0]     BIAS   = IDX_BIAS,
  parameter logic [IDX_W-1:0]     SAT    = IDX_SAT
) (
  input  logic [DATA_W-1:0] x,
  output logic [IDX_W-1:0]  idx,
  output logic [IDX_W-1:0]  idx_next,
  output logic [FRAC_W-1:0] frac
);

  localparam logic [IDX_W-1:0] ONE = 1;

  assign idx      = x[DATA_W-1:FRAC_W] ^ BIAS;
  // The last segment reads its own entry twice instead of wrapping to entry 0
  assign idx_next = (idx == SAT) ? SAT : idx + ONE;
  assign frac     = x[FRAC_W-1:0];

endmodule

// File: rtl/relu_lut_fetcher.sv
// Activation LUT fetcher: splits x, reads two neighbouring entries from an
// external synchronous ROM and presents {base, next__data, remaining}.
// Optional macro LUT_ZERO_FRAC_SKIP_EN: a zero fraction skips the second read.
module relu_lut_fetcher
  import lut_fetch_pkg::*;
#(
  parameter int IDX_W  = LUT_IDX_W,
  parameter int FRAC_W = LUT_FRAC_W,
  parameter int DATA_W = LUT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in__valid,
  output logic              in__ready,
  input  logic [DATA_W-1:0] x,
  output logic [IDX_W-1:0]  tbl__addr,
  input  logic [DATA_W-1:0] tbl__rdata,
  output logic              out__valid,
  input  logic              out__ready,
  output logic [DATA_W-1:0] base,
  output logic [DATA_W-1:0] next__data,
  output logic [DATA_W-1:0] remaining,
  output state_t            state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. A source holds its payload stable while valid=1 and ready=0, and
  // valid never depends combinationally on ready on either side.

  state_t              state;
  state_t              state_nxt;
  logic                ready_q;
  logic [IDX_W-1:0]    addr_q;
  logic [IDX_W-1:0]    idx_next_q;
  logic [FRAC_W-1:0]   frac_q;
  logic [DATA_W-1:0]   base_q;
  logic [DATA_W-1:0]   next_q;
  logic [DATA_W-1:0]   rem_q;

  logic [IDX_W-1:0]    s_idx;
  logic [IDX_W-1:0]    s_idx_next;
  logic [FRAC_W-1:0]   s_frac;

  logic                accept;
  logic                ld_base;
  logic                ld_next;

  lut_index_split #(
    .IDX_W  (IDX_W),
    .FRAC_W (FRAC_W),
    .DATA_W (DATA_W)
  ) u_split (
    .x        (x),
    .idx      (s_idx),
    .idx_next (s_idx_next),
    .frac     (s_frac)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ld_base   = 1'b0;
    ld_next   = 1'b0;
    case (state)
      IDLE: begin
        if (in__valid && ready_q) begin
          accept    = 1'b1;
          state_nxt = RD_BASE;
        end
      end
      RD_BASE: state_nxt = RD_NEXT;
      RD_NEXT: begin
        ld_base = 1'b1;
`ifdef LUT_ZERO_FRAC_SKIP_EN
        state_nxt = (frac_q == '0) ? OUT : RD_LAST;
`else
        state_nxt = RD_LAST;
`endif
      end
      RD_LAST: begin
        ld_next   = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        if (out__ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ready_q stays low for the first cycle after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q    <= 1'b0;
      addr_q     <= '0;
      idx_next_q <= '0;
      frac_q     <= '0;
    end else begin
      ready_q <= (state_nxt == IDLE);
      if (accept) begin
        addr_q     <= s_idx;
        idx_next_q <= s_idx_next;
        frac_q     <= s_frac;
      end else if (state == RD_BASE) begin
        addr_q <= idx_next_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      next_q <= '0;
      rem_q  <= '0;
    end else begin
      if (ld_base) base_q <= tbl__rdata;
`ifdef LUT_ZERO_FRAC_SKIP_EN
      if (ld_base && (frac_q == '0)) begin
        next_q <= tbl__rdata;
        rem_q  <= '0;
      end
`endif
      if (ld_next) begin
        next_q <= tbl__rdata;
        rem_q  <= {{(DATA_W-FRAC_W){1'b0}}, frac_q};
      end
    end
  end

  assign in__ready  = ready_q;
  assign tbl__addr  = addr_q;
  assign out__valid = (state == OUT);
  assign base       = base_q;
  assign next__data = next_q;
  assign remaining  = rem_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_relu_lut_fetcher.sv
// Directed bench for relu_lut_fetcher with a synchronous model ROM holding
// entry k = 8k-64; honours LUT_ZERO_FRAC_SKIP_EN for expected latency.
module tb_relu_lut_fetcher;
  import lut_fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [3:0]  tbl_addr;
  logic [7:0]  tbl_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  base;
  logic [7:0]  next_data;
  logic [7:0]  remaining;
  state_t      state_dbg;

  logic [7:0]  rom [16];
  logic [23:0] exp_q [$];
  int          n_checks;
  int          n_errors;

`ifdef LUT_ZERO_FRAC_SKIP_EN
  localparam int LAT_ZF = 2;
`else
  localparam int LAT_ZF = 3;
`endif

  relu_lut_fetcher dut (
    .clk        (clk),
    .rst        (rst),
    .in__valid  (in_valid),
    .in__ready  (in_ready),
    .x          (x),
    .tbl__addr  (tbl_addr),
    .tbl__rdata (tbl_rdata),
    .out__valid (out_valid),
    .out__ready (out_ready),
    .base       (base),
    .next__data (next_data),
    .remaining  (remaining),
    .state_dbg  (state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 16; k++) rom[k] = 8'(8 * k - 64);
  end

  always @(posedge clk) tbl_rdata <= rom[tbl_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every handshaken triple must match the head of exp_q
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_triple", {8'h0, base, next_data, remaining}, 32'hffffffff);
      end else begin
        check("triple", {8'h0, base, next_data, remaining}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  // driver: one transaction with expected addresses, latency and hold cycles
  task automatic run_txn(input logic [7:0] xv, input logic [3:0] e_idx, input logic [3:0] e_nidx,
                         input int e_lat, input int hold, input logic [23:0] e_tri);
    int cyc;
    exp_q.push_back(e_tri);
    @(negedge clk);
    in_valid  = 1'b1;
    x         = xv;
    out_ready = (hold == 0);
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x        = 8'($urandom_range(0, 255));
    check("in_ready_busy", {31'b0, in_ready}, 32'd0);
    check("addr_base", {28'b0, tbl_addr}, {28'b0, e_idx});
    @(posedge clk); #1;
    check("addr_next", {28'b0, tbl_addr}, {28'b0, e_nidx});
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, e_lat);
    check("triple_at_valid", {8'h0, base, next_data, remaining}, {8'h0, e_tri});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_triple", {8'h0, base, next_data, remaining}, {8'h0, e_tri});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_drop", {31'b0, out_valid}, 32'd0);
    check("in_ready_after", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    x         = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_triple", {8'h0, base, next_data, remaining}, 32'd0);
    check("rst_addr", {28'b0, tbl_addr}, 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // x=0x00: idx 8 -> 0, 8
    run_txn(8'h00, 4'd8, 4'd9, LAT_ZF, 0, {8'h00, 8'h08, 8'h00});
    // x=-128: idx 0 -> -64, -56
    run_txn(8'h80, 4'd0, 4'd1, LAT_ZF, 0, {8'hC0, 8'hC8, 8'h00});
    // x=0x7F: idx 15 read twice -> 56, 56, frac 15
    run_txn(8'h7F, 4'd15, 4'd15, 3, 0, {8'h38, 8'h38, 8'h0F});
    // x=0x35 with consumer stalled 5 cycles: idx 11 -> 24, 32, 5
    run_txn(8'h35, 4'd11, 4'd12, 3, 5, {8'h18, 8'h20, 8'h05});

    // reset while 0x42 is in RD_NEXT
    @(negedge clk);
    in_valid = 1'b1;
    x        = 8'h42;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_state", 32'(state_dbg), 32'(RD_NEXT));
    #2 rst = 1'b0;
    #1;
    check("mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_triple", {8'h0, base, next_data, remaining}, 32'd0);
    check("mid_in_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_ready", {31'b0, in_ready}, 32'd1);
    // x=0x10: idx 9 -> 8, 16, 0
    run_txn(8'h10, 4'd9, 4'd10, LAT_ZF, 0, {8'h08, 8'h10, 8'h00});

    // back-to-back sources with consumer always ready
    exp_q.push_back({8'h08, 8'h10, 8'h01});
    exp_q.push_back({8'h10, 8'h18, 8'h02});
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    x        = 8'h11;
    @(posedge clk); #1;
    x   = 8'h22;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("b2b_second_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("b2b_drain", exp_q.size(), 32'd0);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("final_idle", 32'(state_dbg), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
